// File: rtl/sram_rd_pkg.sv
// sram_rd_pkg: shared defaults and FSM state encoding for the SRAM result reader.
// Revision: 1.0
`default_nettype none

package sram_rd_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 18;
    localparam int WORD_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sram_result_reader.sv
// sram_result_reader: burst-reads SRAM words and hands the low DATA_W bits out over valid/ready.
// Optional macro SRAM_RD_PAD_CHECK_EN flags non-zero upper padding bits via sticky pad_err.
// Revision: 1.0
`default_nettype none

module sram_result_reader
    import sram_rd_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              sram_cs_n,
    output logic              sram_we_n,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic              sram_ry,
    input  logic [WORD_W-1:0] sram_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              pad_err
);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_rem;
    logic [DATA_W-1:0]   r_out_data;
    logic [ADDR_W-1:0]   r_out_addr;
    logic                r_out_valid;

    logic w_launch;
    logic w_capture;
    logic w_accept;
    logic w_last;

    assign w_launch  = (r_state == ST_IDLE) && start && (count != '0);
    assign w_capture = (r_state == ST_WAIT) && sram_ry;
    assign w_accept  = (r_state == ST_OUT) && r_out_valid && out_ready;
    assign w_last    = (r_rem == (ADDR_W+1)'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (count == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ:  w_next = ST_WAIT;
            ST_WAIT: begin
                if (sram_ry) begin
                    w_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (w_accept) begin
                    w_next = w_last ? ST_DONE : ST_REQ;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // r_addr stays put through WAIT so the SRAM sees a stable address until data returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_rem       <= '0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_launch) begin
                r_addr <= start_addr;
                r_rem  <= count;
            end
            if (w_capture) begin
                r_out_data  <= sram_rdata[DATA_W-1:0];
                r_out_addr  <= r_addr;
                r_out_valid <= 1'b1;
            end
            if (w_accept) begin
                r_out_valid <= 1'b0;
                r_rem       <= r_rem - (ADDR_W+1)'(1);
                if (!w_last) begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
        end
    end

`ifdef SRAM_RD_PAD_CHECK_EN
    logic r_pad_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pad_err <= 1'b0;
        end else if (w_capture && (|sram_rdata[WORD_W-1:DATA_W])) begin
            r_pad_err <= 1'b1;
        end
    end

    assign pad_err = r_pad_err;
`else
    logic w_unused_pad;

    assign w_unused_pad = |sram_rdata[WORD_W-1:DATA_W];
    assign pad_err      = 1'b0;
`endif

    assign busy      = (r_state == ST_REQ) || (r_state == ST_WAIT) || (r_state == ST_OUT);
    assign done      = (r_state == ST_DONE);
    assign sram_cs_n = (r_state != ST_REQ);
    assign sram_we_n = 1'b1;
    assign sram_addr = r_addr;
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;
    assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_sram_result_reader.sv
// tb_sram_result_reader: randomized bench with an event-level reference model and directed literal checks.
// Revision: 1.0
`default_nettype none

module tb_sram_result_reader;

`ifdef SRAM_RD_PAD_CHECK_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  start_addr;
    logic [8:0]  count;
    logic        busy;
    logic        done;
    logic        sram_cs_n;
    logic        sram_we_n;
    logic [7:0]  sram_addr;
    logic        sram_ry;
    logic [31:0] sram_rdata;
    logic [17:0] out_data;
    logic [7:0]  out_addr;
    logic        out_valid;
    logic        out_ready;
    logic        pad_err;

    logic [31:0] mem [256];
    assign sram_rdata = mem[sram_addr];

    sram_result_reader #(.ADDR_W(8), .DATA_W(18), .WORD_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .count(count),
        .busy(busy), .done(done), .sram_cs_n(sram_cs_n), .sram_we_n(sram_we_n),
        .sram_addr(sram_addr), .sram_ry(sram_ry), .sram_rdata(sram_rdata),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
        .out_ready(out_ready), .pad_err(pad_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: what the outputs must show in the current cycle.
    bit          m_active, m_pending, m_hold, m_req, m_done, m_pad;
    logic [7:0]  m_addr, m_oaddr;
    logic [17:0] m_odata;
    logic [8:0]  m_left;

    logic [7:0]  hs_addr[$];
    logic [17:0] hs_data[$];
    int t_start, t_valid, t_hs, t_done;
    int cs_cnt = 0, valid_cnt = 0, done_cnt = 0;
    bit seen_valid;

    always @(negedge clk) begin
        bit n_req, n_done;
        if (!rst_n) begin
            m_active = 0; m_pending = 0; m_hold = 0; m_req = 0; m_done = 0; m_pad = 0;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_data", out_data, 0);
            chk("rst_oaddr", out_addr, 0);
            chk("rst_cs_n", sram_cs_n, 1);
            chk("rst_saddr", sram_addr, 0);
            chk("rst_pad", pad_err, 0);
        end else begin
            chk("busy", busy, m_active);
            chk("done", done, m_done);
            chk("cs_n", sram_cs_n, !m_req);
            chk("we_n", sram_we_n, 1);
            chk("out_valid", out_valid, m_hold);
            chk("pad_err", pad_err, m_pad);
            if (m_req) chk("sram_addr", sram_addr, m_addr);
            if (m_hold) begin
                chk("out_addr", out_addr, m_oaddr);
                chk("out_data", out_data, m_odata);
            end
            if (!sram_cs_n) cs_cnt++;
            if (out_valid) valid_cnt++;
            if (done) begin done_cnt++; t_done = cyc; end
            if (out_valid && !seen_valid) begin t_valid = cyc; seen_valid = 1; end
            if (out_valid && out_ready) begin
                hs_addr.push_back(out_addr);
                hs_data.push_back(out_data);
                t_hs = cyc;
            end

            n_req = 0; n_done = 0;
            if (!m_active && !m_done) begin
                if (start) begin
                    t_start = cyc; seen_valid = 0;
                    if (count == 0) n_done = 1;
                    else begin
                        m_active = 1; n_req = 1; m_addr = start_addr; m_left = count;
                    end
                end
            end else if (m_req) begin
                m_pending = 1;
            end else if (m_pending) begin
                if (sram_ry) begin
                    m_pending = 0; m_hold = 1;
                    m_oaddr = m_addr;
                    m_odata = mem[m_addr][17:0];
                    if (mem[m_addr][31:18] != 0) m_pad = PAD_EN;
                end
            end else if (m_hold && out_ready) begin
                m_hold = 0;
                m_left = m_left - 1;
                if (m_left == 0) begin m_active = 0; n_done = 1; end
                else begin m_addr = m_addr + 1; n_req = 1; end
            end
            m_req  = n_req;
            m_done = n_done;
        end
    end

    int ry_pct = 100, rdy_pct = 100;
    bit spur_en = 0;

    task automatic drive_rand();
        sram_ry    = ($urandom_range(99) < ry_pct);
        out_ready  = ($urandom_range(99) < rdy_pct);
        start      = spur_en && m_active && ($urandom_range(9) == 0);
        start_addr = 8'($urandom);
        count      = 9'($urandom_range(256));
    endtask

    task automatic do_start(input logic [7:0] a, input logic [8:0] c);
        @(posedge clk); #1;
        sram_ry   = ($urandom_range(99) < ry_pct);
        out_ready = ($urandom_range(99) < rdy_pct);
        start = 1'b1; start_addr = a; count = c;
        @(posedge clk); #1;
        drive_rand();
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        forever begin
            @(posedge clk); #1;
            if (!m_active && !m_done) begin
                start = 1'b0;
                break;
            end
            n++;
            if (n > limit) begin
                n_checks++; n_fail++;
                $display("FAIL wait_idle: burst still active after %0d cycles", limit);
                start = 1'b0;
                break;
            end
            drive_rand();
        end
    endtask

    task automatic reset_now();
        @(posedge clk); #2;
        rst_n = 1'b0; start = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_cs_n", sram_cs_n, 1);
        chk("async_rst_data", out_data, 0);
        chk("async_rst_pad", pad_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int cs0, v0, d0;
        rst_n = 1'b0; start = 1'b0; start_addr = '0; count = '0;
        sram_ry = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = {14'h0, 18'($urandom)};
        for (int i = 0; i < 4; i++) mem[8'h10 + i] = 32'h0002_A5A0 + i;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Four-word burst, SRAM always ready, consumer always ready.
        ry_pct = 100; rdy_pct = 100; spur_en = 0;
        hs_addr.delete(); hs_data.delete();
        do_start(8'h10, 9'd4);
        wait_idle(200);
        chk("b037_n", hs_addr.size(), 4);
        if (hs_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("b037_addr", hs_addr[i], 8'h10 + i);
                chk("b037_data", hs_data[i], 18'h2A5A0 + i);
            end
        end
        chk("b037_latency", t_valid - t_start, 3);
        chk("b037_done_lag", t_done - t_hs, 1);

        // Address wrap.
        hs_addr.delete(); hs_data.delete();
        do_start(8'hFE, 9'd3);
        wait_idle(200);
        chk("b038_n", hs_addr.size(), 3);
        if (hs_addr.size() == 3) begin
            chk("b038_a0", hs_addr[0], 8'hFE);
            chk("b038_a1", hs_addr[1], 8'hFF);
            chk("b038_a2", hs_addr[2], 8'h00);
        end

        // Zero-length request.
        cs0 = cs_cnt; v0 = valid_cnt; d0 = done_cnt;
        do_start(8'h55, 9'd0);
        wait_idle(20);
        chk("b039_cs", cs_cnt - cs0, 0);
        chk("b039_valid", valid_cnt - v0, 0);
        chk("b039_done", done_cnt - d0, 1);
        chk("b039_done_lag", t_done - t_start, 1);

        // SRAM slow by 4 cycles, consumer stalls 5 cycles.
        ry_pct = 0; rdy_pct = 0;
        hs_addr.delete(); hs_data.delete();
        cs0 = cs_cnt;
        do_start(8'h40, 9'd1);
        for (int j = 2; j <= 14; j++) begin
            @(posedge clk); #1;
            sram_ry   = (j >= 6);
            out_ready = (j >= 12);
        end
        ry_pct = 100; rdy_pct = 100;
        wait_idle(50);
        chk("b040_latency", t_valid - t_start, 7);
        chk("b040_stall", t_hs - t_valid, 5);
        chk("b040_cs", cs_cnt - cs0, 1);
        chk("b040_addr", (hs_addr.size() == 1) ? hs_addr[0] : 8'hxx, 8'h40);

        // Reset while holding an output word mid-burst.
        ry_pct = 100; rdy_pct = 0;
        do_start(8'h80, 9'd8);
        for (int j = 0; j < 20 && !out_valid; j++) begin
            @(posedge clk); #1;
        end
        chk("b041_reached_out", out_valid, 1);
        reset_now();
        rdy_pct = 100;
        hs_addr.delete(); hs_data.delete();
        do_start(8'h33, 9'd2);
        wait_idle(100);
        chk("b041_n", hs_addr.size(), 2);
        if (hs_addr.size() == 2) begin
            chk("b041_a0", hs_addr[0], 8'h33);
            chk("b041_a1", hs_addr[1], 8'h34);
        end

        // Padding bits.
        mem[8'h20] = 32'h0004_0001;
        hs_addr.delete(); hs_data.delete();
        do_start(8'h20, 9'd1);
        wait_idle(50);
        chk("b042_data", (hs_data.size() == 1) ? hs_data[0] : 18'hxxxxx, 18'h00001);
        repeat (3) @(posedge clk);
        #1 chk("b042_pad", pad_err, PAD_EN);
        reset_now();
        #1 chk("b042_pad_cleared", pad_err, 0);

        // Randomized bursts with stalls, spurious starts and occasional mid-burst resets.
        for (int i = 0; i < 256; i++)
            mem[i] = {($urandom_range(7) == 0) ? 14'($urandom) : 14'h0, 18'($urandom)};
        spur_en = 1;
        for (int b = 0; b < 40; b++) begin
            logic [8:0] c;
            ry_pct  = $urandom_range(20, 100);
            rdy_pct = $urandom_range(20, 100);
            if (b == 17)                          c = 9'd256;
            else if ($urandom_range(9) == 0)      c = 9'd0;
            else                                  c = 9'($urandom_range(1, 12));
            do_start(8'($urandom), c);
            if ($urandom_range(5) == 0) begin
                repeat ($urandom_range(1, 15)) begin
                    @(posedge clk); #1;
                    drive_rand();
                end
                reset_now();
            end else begin
                wait_idle(20000);
            end
        end
        spur_en = 0;
        start = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_result_reader.md
SRAM_RESULT_READER -- requirements
Module: sram_result_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, SRAM word address width.
REQ-002 SHALL have parameter DATA_W, default 18, result width extracted from each SRAM word.
REQ-003 SHALL have parameter WORD_W, default 32, SRAM read-data width.
REQ-004 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a burst read.
REQ-007 SHALL have port start_addr  in  ADDR_W  first word address.
REQ-008 SHALL have port count  in  ADDR_W+1  words to read, 0..256.
REQ-009 SHALL have port busy  out  1  burst in progress.
REQ-010 SHALL have port done  out  1  one-cycle pulse at burst end.
REQ-011 SHALL have port sram_cs_n  out  1  SRAM chip select, active low.
REQ-012 SHALL have port sram_we_n  out  1  SRAM write enable, active low; constant 1.
REQ-013 SHALL have port sram_addr  out  ADDR_W  SRAM address.
REQ-014 SHALL have port sram_ry  in  1  SRAM read data ready.
REQ-015 SHALL have port sram_rdata  in  WORD_W  SRAM read data.
REQ-016 SHALL have port out_data  out  DATA_W  result word.
REQ-017 SHALL have port out_addr  out  ADDR_W  address out_data came from.
REQ-018 SHALL have port out_valid  out  1  out_data valid.
REQ-019 SHALL have port out_ready  in  1  consumer accepts out_data.
REQ-020 SHALL have port pad_err  out  1  sticky padding-check error (see Configuration).

Function
REQ-021 SHALL implement FSM states IDLE, REQ, WAIT, OUT, DONE.
REQ-022 IDLE: start=1 and count!=0 SHALL latch start_addr/count and go to REQ; start=1 and count=0 SHALL go to DONE with no SRAM access.
REQ-023 start while not IDLE SHALL be ignored.
REQ-024 REQ (one cycle): sram_cs_n=0, sram_addr=current address; next state WAIT.
REQ-025 WAIT: sram_cs_n=1; wait unbounded for sram_ry=1, then capture sram_rdata[DATA_W-1:0] into out_data, the address into out_addr, set out_valid, go to OUT.
REQ-026 OUT: out_data/out_addr/out_valid SHALL hold stable until out_valid&&out_ready; on handshake clear out_valid and decrement remaining; remaining reaches 0 -> DONE, else address+1 -> REQ.
REQ-027 Address increment SHALL wrap 8'hFF -> 8'h00; count=256 reads all words exactly once.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE.
REQ-029 busy SHALL be 1 in REQ, WAIT, OUT, 0 in IDLE and DONE.
REQ-030 Latency: start at cycle 0, sram_ry=1 in cycle 2 -> out_valid=1 in cycle 3; minimum 3 cycles per word.
REQ-031 sram_cs_n SHALL be 1 in every state except REQ; sram_we_n SHALL be 1 always.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, out_valid=0, out_data=0, out_addr=0, sram_cs_n=1, sram_addr=0, pad_err=0, including mid-burst; no partial burst resumes.

Configuration
REQ-033 Macro SRAM_RD_PAD_CHECK_EN defined: on each WAIT capture, sram_rdata[WORD_W-1:DATA_W]!=0 SHALL set pad_err, sticky until reset.
REQ-034 Macro undefined: upper bits ignored, pad_err tied 0.

Structure
REQ-035 Package sram_rd_pkg SHALL hold ADDR_W/DATA_W/WORD_W defaults and the FSM state enum.
REQ-036 No sub-module; integration instantiates sram_wrapper beside this block and muxes its cs_n/we_n/address with the writer side.

Verification
REQ-037 start, start_addr=8'h10, count=4, ry=1 next cycle, out_ready=1 -> out_addr 10,11,12,13 with matching low 18 bits, done 1 cycle after last handshake.
REQ-038 start_addr=8'hFE, count=3 -> addresses FE, FF, 00.
REQ-039 count=0 -> done pulse, sram_cs_n never low, out_valid never high.
REQ-040 out_ready low 5 cycles with out_valid=1 -> out_data/out_addr unchanged, no new sram_cs_n pulse; sram_ry held low 4 cycles -> out_valid delayed 4 cycles.
REQ-041 rst_n low during OUT of a count=8 burst -> all outputs at reset values the same cycle; new start reads from its own start_addr.
REQ-042 SRAM_RD_PAD_CHECK_EN defined, sram_rdata=32'h0004_0001 -> out_data=18'h00001, pad_err=1 until reset; macro undefined -> pad_err=0.
